// File: rtl/bus_port_pkg.sv
// rtl/bus_port_pkg.sv - shared types, error-bit indices and helpers for bus_port_fifo
package bus_port_pkg;

    localparam int PCKG_SZ = 16;

    typedef logic [PCKG_SZ-1:0] pckt_t;

    localparam int ERR_TX_OVF = 0;
    localparam int ERR_TX_UDF = 1;
    localparam int ERR_RX_OVF = 2;
    localparam int ERR_RX_UDF = 3;

    // Sticky flag update: a new error in the clearing cycle still lands.
    function automatic logic [3:0] err_next(input logic [3:0] cur,
                                            input logic       clr,
                                            input logic [3:0] evt);
        return (clr ? 4'b0000 : cur) | evt;
    endfunction

endpackage

// File: rtl/fwft_fifo.sv
// rtl/fwft_fifo.sv - first-word-fall-through queue with overflow/underflow pulses
module fwft_fifo #(
    parameter int width = 16,
    parameter int depth = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr,
    input  logic [width-1:0]       wdata,
    input  logic                   rd,
    output logic [width-1:0]       rdata,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(depth):0] cnt,
    output logic                   ovf,
    output logic                   udf
);

    localparam int AW = $clog2(depth);
    localparam int CW = AW + 1;

    logic [width-1:0] mem [depth];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             wr_ok;
    logic             rd_ok;

    // A read frees a slot in the same edge, so a full queue still takes a write alongside a read.
    always_comb begin
        empty = (cnt == '0);
        full  = (cnt == CW'(depth));
        rd_ok = rd & ~empty;
        wr_ok = wr & (~full | rd);
        ovf   = wr & full & ~rd;
        udf   = rd & empty;
        rdata = empty ? '0 : mem[rd_ptr];
    end

    // Storage is intentionally left unreset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally because depth is a power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({wr_ok, rd_ok})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/bus_port_fifo.sv
// rtl/bus_port_fifo.sv - per-driver TX/RX buffering between a bus device and the arbiter
module bus_port_fifo
    import bus_port_pkg::*;
#(
    parameter int pckg_sz = PCKG_SZ,
    parameter int depth   = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   dev_wr,
    input  logic [pckg_sz-1:0]     dev_wdata,
    output logic                   tx_full,
    output logic [$clog2(depth):0] tx_cnt,
    output logic                   pndng,
    output logic [pckg_sz-1:0]     D_pop,
    input  logic                   pop,
    input  logic                   push,
    input  logic [pckg_sz-1:0]     D_push,
    input  logic                   dev_rd,
    output logic                   rx_valid,
    output logic [pckg_sz-1:0]     dev_rdata,
    output logic                   rx_full,
    output logic [$clog2(depth):0] rx_cnt,
    output logic [3:0]             err,
    input  logic                   clr_err
);

    logic       tx_empty;
    logic       rx_empty;
    logic       tx_ovf;
    logic       tx_udf;
    logic       rx_ovf;
    logic       rx_udf;
    logic [3:0] err_evt;

    fwft_fifo #(.width(pckg_sz), .depth(depth)) u_tx (
        .clk   (clk),
        .reset (reset),
        .wr    (dev_wr),
        .wdata (dev_wdata),
        .rd    (pop),
        .rdata (D_pop),
        .empty (tx_empty),
        .full  (tx_full),
        .cnt   (tx_cnt),
        .ovf   (tx_ovf),
        .udf   (tx_udf)
    );

    fwft_fifo #(.width(pckg_sz), .depth(depth)) u_rx (
        .clk   (clk),
        .reset (reset),
        .wr    (push),
        .wdata (D_push),
        .rd    (dev_rd),
        .rdata (dev_rdata),
        .empty (rx_empty),
        .full  (rx_full),
        .cnt   (rx_cnt),
        .ovf   (rx_ovf),
        .udf   (rx_udf)
    );

    // Gather this cycle's queue events into the err bit layout.
    always_comb begin
        pndng               = ~tx_empty;
        rx_valid            = ~rx_empty;
        err_evt             = 4'b0000;
        err_evt[ERR_TX_OVF] = tx_ovf;
        err_evt[ERR_TX_UDF] = tx_udf;
        err_evt[ERR_RX_OVF] = rx_ovf;
        err_evt[ERR_RX_UDF] = rx_udf;
    end

    // Sticky error flags, cleared only by clr_err.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err <= 4'b0000;
        end else begin
            err <= err_next(err, clr_err, err_evt);
        end
    end

endmodule

// File: tb/tb_bus_port_fifo.sv
// tb/tb_bus_port_fifo.sv - directed self-checking bench for bus_port_fifo
module tb_bus_port_fifo;

    localparam int W = 16;
    localparam int D = 8;

    logic         clk;
    logic         reset;
    logic         dev_wr;
    logic [W-1:0] dev_wdata;
    logic         tx_full;
    logic [3:0]   tx_cnt;
    logic         pndng;
    logic [W-1:0] D_pop;
    logic         pop;
    logic         push;
    logic [W-1:0] D_push;
    logic         dev_rd;
    logic         rx_valid;
    logic [W-1:0] dev_rdata;
    logic         rx_full;
    logic [3:0]   rx_cnt;
    logic [3:0]   err;
    logic         clr_err;

    int checks = 0;
    int errors = 0;

    bus_port_fifo #(.pckg_sz(W), .depth(D)) dut (
        .clk       (clk),
        .reset     (reset),
        .dev_wr    (dev_wr),
        .dev_wdata (dev_wdata),
        .tx_full   (tx_full),
        .tx_cnt    (tx_cnt),
        .pndng     (pndng),
        .D_pop     (D_pop),
        .pop       (pop),
        .push      (push),
        .D_push    (D_push),
        .dev_rd    (dev_rd),
        .rx_valid  (rx_valid),
        .dev_rdata (dev_rdata),
        .rx_full   (rx_full),
        .rx_cnt    (rx_cnt),
        .err       (err),
        .clr_err   (clr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0; dev_wr = 0; dev_wdata = '0; pop = 0;
        push = 0; D_push = '0; dev_rd = 0; clr_err = 0;
        step(); step();
        reset = 1'b1;
        step();

        chk("idle_pndng", pndng, 0);
        chk("idle_dpop", D_pop, 0);
        chk("idle_rx_valid", rx_valid, 0);
        chk("idle_tx_cnt", tx_cnt, 0);
        chk("idle_rx_cnt", rx_cnt, 0);
        chk("idle_err", err, 0);
        chk("idle_tx_full", tx_full, 0);
        chk("idle_rdata", dev_rdata, 0);

        dev_wr = 1; dev_wdata = 16'h0A01; step();
        chk("wr1_pndng", pndng, 1);
        chk("wr1_dpop", D_pop, 16'h0A01);
        dev_wdata = 16'h0A02; step();
        dev_wdata = 16'h0A03; step();
        dev_wr = 0;
        chk("wr3_cnt", tx_cnt, 3);
        chk("wr3_dpop", D_pop, 16'h0A01);
        pop = 1; step();
        chk("pop1_dpop", D_pop, 16'h0A02);
        chk("pop1_cnt", tx_cnt, 2);
        step();
        chk("pop2_dpop", D_pop, 16'h0A03);
        step();
        pop = 0;
        chk("pop3_pndng", pndng, 0);
        chk("pop3_dpop", D_pop, 0);
        chk("pop3_err", err, 0);

        dev_wr = 1;
        for (int i = 0; i < 9; i++) begin
            dev_wdata = 16'h1000 + 16'(i);
            step();
            if (i == 7) begin
                chk("fill8_full", tx_full, 1);
                chk("fill8_err", err, 0);
            end
        end
        dev_wr = 0;
        chk("ovf_cnt", tx_cnt, 8);
        chk("ovf_err", err, 4'b0001);
        pop = 1;
        for (int i = 0; i < 8; i++) begin
            chk("drain_data", D_pop, 16'h1000 + 16'(i));
            step();
        end
        pop = 0;
        chk("drain_pndng", pndng, 0);
        chk("drain_err", err, 4'b0001);
        clr_err = 1; step(); clr_err = 0;
        chk("clr_err", err, 0);

        dev_wr = 1;
        for (int i = 0; i < 8; i++) begin
            dev_wdata = 16'h2000 + 16'(i);
            step();
        end
        dev_wdata = 16'h2008; pop = 1; step();
        dev_wr = 0;
        chk("fullrw_dpop", D_pop, 16'h2001);
        chk("fullrw_cnt", tx_cnt, 8);
        chk("fullrw_full", tx_full, 1);
        chk("fullrw_err", err, 0);
        for (int i = 1; i < 9; i++) begin
            chk("fullrw_drain", D_pop, 16'h2000 + 16'(i));
            step();
        end
        pop = 0;
        chk("fullrw_empty", pndng, 0);
        chk("fullrw_err2", err, 0);

        push = 1; D_push = 16'hBEEF; dev_rd = 1; step();
        push = 0; dev_rd = 0;
        chk("rxe_cnt", rx_cnt, 1);
        chk("rxe_rdata", dev_rdata, 16'hBEEF);
        chk("rxe_valid", rx_valid, 1);
        chk("rxe_err", err, 4'b1000);
        dev_rd = 1; step();
        chk("rxrd_cnt", rx_cnt, 0);
        chk("rxrd_rdata", dev_rdata, 0);
        step();
        dev_rd = 0;
        chk("rxudf_err", err, 4'b1000);
        chk("rxudf_cnt", rx_cnt, 0);
        clr_err = 1; dev_rd = 1; step();
        clr_err = 0; dev_rd = 0;
        chk("clr_vs_new", err, 4'b1000);
        clr_err = 1; step(); clr_err = 0;
        chk("rx_clr", err, 0);

        push = 1;
        for (int i = 0; i < 9; i++) begin
            D_push = 16'h3000 + 16'(i);
            step();
        end
        push = 0;
        chk("rxovf_full", rx_full, 1);
        chk("rxovf_cnt", rx_cnt, 8);
        chk("rxovf_err", err, 4'b0100);
        dev_rd = 1;
        for (int i = 0; i < 6; i++) begin
            chk("rx_drain", dev_rdata, 16'h3000 + 16'(i));
            step();
        end
        dev_rd = 0;
        chk("rx_left", rx_cnt, 2);

        dev_wr = 1;
        for (int i = 0; i < 5; i++) begin
            dev_wdata = 16'h4000 + 16'(i);
            step();
        end
        dev_wr = 0;
        chk("pre_rst_tx", tx_cnt, 5);
        #2;
        reset = 1'b0;
        #1;
        chk("rst_pndng", pndng, 0);
        chk("rst_tx_cnt", tx_cnt, 0);
        chk("rst_rx_cnt", rx_cnt, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_dpop", D_pop, 0);
        chk("rst_err", err, 0);
        #2;
        reset = 1'b1;
        dev_wr = 1; dev_wdata = 16'h0055; step();
        dev_wr = 0;
        chk("post_rst_dpop", D_pop, 16'h0055);
        chk("post_rst_cnt", tx_cnt, 1);
        chk("post_rst_rx", rx_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_port_fifo.md
Name: bus_port_fifo

Overview:
- Per-driver buffering stage between one bus device and the bus generator/arbiter. One instance per driver port.
- TX side: the device writes packets. The block presents them to the arbiter as pending/pop-data and consumes the arbiter's pop.
- RX side: captures the arbiter's push/D_push into a receive queue that the device drains.
- Both queues are first-word-fall-through (FWFT), so the head packet is visible whenever the queue is non-empty.

Parameters:
- pckg_sz, 16, packet width in bits.
- depth, 8, entries per queue; must be a power of 2 and ≥2.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- dev_wr  in  1  device writes dev_wdata into the TX queue.
- dev_wdata  in  pckg_sz  TX packet from the device.
- tx_full  out  1  TX queue holds depth entries.
- tx_cnt  out  $clog2(depth)+1  TX occupancy.
- pndng  out  1  TX queue non-empty; driven to the arbiter.
- D_pop  out  pckg_sz  TX head packet; all zeros when empty.
- pop  in  1  arbiter consumes the TX head.
- push  in  1  arbiter delivers D_push to this port.
- D_push  in  pckg_sz  RX packet from the arbiter.
- dev_rd  in  1  device consumes the RX head.
- rx_valid  out  1  RX queue non-empty.
- dev_rdata  out  pckg_sz  RX head packet; all zeros when empty.
- rx_full  out  1  RX queue holds depth entries.
- rx_cnt  out  $clog2(depth)+1  RX occupancy.
- err  out  4  sticky flags: [0] tx_ovf, [1] tx_udf, [2] rx_ovf, [3] rx_udf.
- clr_err  in  1  synchronous clear of err.

Behaviour:
- Reset low (async): all pointers, counters and err go to 0. Outputs become pndng=0, D_pop=0, tx_full=0, rx_valid=0, dev_rdata=0, rx_full=0. Memory contents are not cleared. Reset mid-transfer discards all queued packets; the first cycle after deassertion behaves as empty.
- Write latency: a write accepted at edge N makes pndng/rx_valid high and D_pop/dev_rdata valid immediately after edge N. No same-cycle bypass from write to read.
- Pop/read removes the head at the edge. The next entry, or zeros if the queue is now empty, appears immediately after that edge.
- Write while full and no simultaneous read: data is dropped, count unchanged, overflow flag set (err[0] for TX, err[2] for RX).
- Read while empty: ignored, count unchanged, underflow flag set (err[1] for TX, err[3] for RX).
- Simultaneous write and read when full: both succeed, count unchanged, no flag.
- Simultaneous write and read when empty: write succeeds, read ignored, underflow flag set, count becomes 1.
- Simultaneous write and read otherwise: both succeed, count unchanged.
- Pointers are $clog2(depth) bits and wrap modulo depth. Count range is 0..depth; full when count==depth.
- err bits are sticky until clr_err. If clr_err and a new error occur in the same cycle, the new error wins (flag stays set).
- TX and RX queues are fully independent; no interaction or ordering between them.
- No internal FSM beyond the per-queue empty/partial/full status derived from the counter. Each queue's state follows its count.

Decomposition:
- Package bus_port_pkg:
  - typedef of the packet vector parameterised by pckg_sz, via a parameterised class or localparam pattern.
  - localparam indices ERR_TX_OVF=0, ERR_TX_UDF=1, ERR_RX_OVF=2, ERR_RX_UDF=3.
- Sub-module fwft_fifo (params width, depth):
  - ports clk, reset, wr, wdata, rd, rdata, empty, full, cnt, ovf, udf.
  - instantiated twice, for TX and RX.
  - the top level maps outputs, with pndng=~empty, and collects the sticky err bits.

Test Plan:
- Reset then idle → pndng=0, D_pop=0, rx_valid=0, tx_cnt=0, rx_cnt=0, err=0.
- Write 0x0A01, 0x0A02, 0x0A03 → pndng=1, D_pop=0x0A01, tx_cnt=3. Three pops return 0x0A01, 0x0A02, 0x0A03 in order, then pndng=0 and D_pop=0.
- Write 9 packets 0x1000..0x1008 with depth=8 → tx_full=1 after the 8th, 0x1008 dropped, err[0]=1. Drain yields 0x1000..0x1007. Then assert clr_err → err=0.
- Full TX with dev_wr=1 and pop=1 together → head advances to the next entry, new packet accepted, tx_cnt stays 8, err=0.
- Arbiter pushes 0xBEEF, device reads in the same cycle (RX empty) → rx_cnt=1, dev_rdata=0xBEEF, err[3]=1. An extra dev_rd on empty RX → err[3] stays set.
- Reset asserted with tx_cnt=5 and rx_cnt=2 → counts go to 0 and pndng drops asynchronously before the next clk edge. Post-reset write of 0x0055 appears as D_pop=0x0055.
